// File: rtl/uart_tx_fifo_if.sv
// Write-side interface of uart_tx_fifo.
//   master : the data producer; drives wr_en/wr_data, watches the FIFO flags.
//   slave  : the transmitter; accepts writes and reports full/empty/fifo_count/overflow.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) ();
    logic                          wr_en;
    logic [DATA_BITS-1:0]          wr_data;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;

    modport master (
        output wr_en, wr_data,
        input  full, empty, fifo_count, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Words written through wr_if are queued and sent back-to-back as
// start / DATA_BITS (LSB first) / optional parity / STOP_BITS stop bits,
// each bit lasting BAUD_DIV = CLK_FREQ / BAUD clock cycles.
// Ports:
//   clk_50m      system clock, rising edge
//   reset        asynchronous active-high reset (aborts any frame, flushes FIFO)
//   wr_if        slave side: wr_en/wr_data in; full/empty/fifo_count/overflow out
//   busy         high from start bit through the last stop bit
//   uart_tx_path registered serial output, idle high
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk_50m,
    input  logic           reset,
    uart_tx_fifo_if.slave  wr_if,
    output logic           busy,
    output logic           uart_tx_path
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int BW       = $clog2(DATA_BITS);

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 overflow_q;
    logic                 full, empty;
    logic                 wr_ok, pop;
    logic [DATA_BITS-1:0] head;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign wr_ok = wr_if.wr_en && !full;
    assign head  = mem[rd_ptr];

    assign wr_if.full       = full;
    assign wr_if.empty      = empty;
    assign wr_if.fifo_count = count;
    assign wr_if.overflow   = overflow_q;

    always_ff @(posedge clk_50m) begin
        if (wr_ok) mem[wr_ptr] <= wr_if.wr_data;
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            // full is the registered occupancy, so a pop on this edge does
            // not rescue a write presented while full.
            overflow_q <= wr_if.wr_en && full;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- Serialiser FSM ----------------
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 baud_last, stop_last, head_par;

    assign baud_last = (baud_cnt == CW'(BAUD_DIV - 1));
    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign head_par  = (PARITY == 1) ? ~^head : ^head;

    // Pop from IDLE, or from the final stop-bit cycle so the next start bit
    // follows with no idle gap.
    assign pop = !empty &&
                 ((state == S_IDLE) || (state == S_STOP && baud_last && stop_last));

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            uart_tx_path <= 1'b1;
            busy         <= 1'b0;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bit      <= 1'b0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state        <= S_START;
                        shreg        <= head;
                        par_bit      <= head_par;
                        uart_tx_path <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        state        <= S_DATA;
                        baud_cnt     <= '0;
                        bit_cnt      <= '0;
                        uart_tx_path <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            stop_idx <= 1'b0;
                            if (PARITY != 0) begin
                                state        <= S_PARITY;
                                uart_tx_path <= par_bit;
                            end else begin
                                state        <= S_STOP;
                                uart_tx_path <= 1'b1;
                            end
                        end else begin
                            bit_cnt      <= bit_cnt + 1'b1;
                            shreg        <= shreg >> 1;
                            uart_tx_path <= shreg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        state        <= S_STOP;
                        baud_cnt     <= '0;
                        stop_idx     <= 1'b0;
                        uart_tx_path <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (!stop_last) begin
                            stop_idx <= 1'b1;
                        end else if (pop) begin
                            state        <= S_START;
                            shreg        <= head;
                            par_bit      <= head_par;
                            uart_tx_path <= 1'b0;
                        end else begin
                            state        <= S_IDLE;
                            uart_tx_path <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    uart_tx_path <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different frame formats,
// checked against a frame model built from the line-format rules.
module tb_uart_tx_fifo;
    localparam int DIV = 10;                       // 50 MHz / 5 MBd
    localparam int DB [4] = '{8, 8, 8, 5};
    localparam int PR [4] = '{0, 2, 1, 0};
    localparam int SB [4] = '{1, 1, 2, 1};

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    logic       wen_v  [4];
    logic [8:0] wdat_v [4];
    logic [3:0] line_v, busy_v, empty_v, full_v, ovf_v;
    logic [4:0] cnt_v  [4];

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if2 ();
    uart_tx_fifo_if #(.DATA_BITS(5), .FIFO_DEPTH(16)) if3 ();

    assign if0.wr_en = wen_v[0];  assign if0.wr_data = wdat_v[0][7:0];
    assign if1.wr_en = wen_v[1];  assign if1.wr_data = wdat_v[1][7:0];
    assign if2.wr_en = wen_v[2];  assign if2.wr_data = wdat_v[2][7:0];
    assign if3.wr_en = wen_v[3];  assign if3.wr_data = wdat_v[3][4:0];

    assign empty_v = {if3.empty, if2.empty, if1.empty, if0.empty};
    assign full_v  = {if3.full, if2.full, if1.full, if0.full};
    assign ovf_v   = {if3.overflow, if2.overflow, if1.overflow, if0.overflow};
    assign cnt_v[0] = if0.fifo_count;
    assign cnt_v[1] = if1.fifo_count;
    assign cnt_v[2] = if2.fifo_count;
    assign cnt_v[3] = if3.fifo_count;

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
        u0 (.clk_50m(clk), .reset(reset), .wr_if(if0), .busy(busy_v[0]), .uart_tx_path(line_v[0]));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
        u1 (.clk_50m(clk), .reset(reset), .wr_if(if1), .busy(busy_v[1]), .uart_tx_path(line_v[1]));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16))
        u2 (.clk_50m(clk), .reset(reset), .wr_if(if2), .busy(busy_v[2]), .uart_tx_path(line_v[2]));
    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(5),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
        u3 (.clk_50m(clk), .reset(reset), .wr_if(if3), .busy(busy_v[3]), .uart_tx_path(line_v[3]));

    int vectors = 0;
    int miscompares = 0;
    int pk, bcnt, ocnt;
    int wq [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fl(input int inst);
        return (1 + DB[inst] + ((PR[inst] != 0) ? 1 : 0) + SB[inst]) * DIV;
    endfunction

    // One mid-cycle sample; also tracks busy cycles, overflow pulses, peak count.
    task automatic sample(input int inst);
        @(negedge clk);
        if (busy_v[inst] === 1'b1) bcnt++;
        if (ovf_v[inst] === 1'b1) ocnt++;
        if (int'(cnt_v[inst]) > pk) pk = int'(cnt_v[inst]);
    endtask

    // Expected line for one frame, derived from the frame-format rules.
    task automatic expect_frame(input int inst, input int data);
        logic b [16];
        int   nb, ones;
        logic lo, bo;
        nb = 0; ones = 0;
        b[nb] = 1'b0; nb++;
        for (int i = 0; i < DB[inst]; i++) begin
            b[nb] = data[i]; nb++;
            ones += data[i];
        end
        if (PR[inst] == 2) begin b[nb] = ((ones % 2) == 1); nb++; end
        if (PR[inst] == 1) begin b[nb] = ((ones % 2) == 0); nb++; end
        for (int i = 0; i < SB[inst]; i++) begin b[nb] = 1'b1; nb++; end
        for (int k = 0; k < nb; k++) begin
            lo = b[k]; bo = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                sample(inst);
                if (line_v[inst] !== b[k]) lo = line_v[inst];
                if (busy_v[inst] !== 1'b1) bo = busy_v[inst];
            end
            chk($sformatf("frame u%0d data=%0h bit%0d {busy,line}", inst, data, k),
                {30'd0, bo, lo}, {30'd0, 1'b1, b[k]});
        end
    endtask

    task automatic idle_check(input int inst);
        sample(inst);
        chk($sformatf("idle u%0d line", inst),  line_v[inst],  1);
        chk($sformatf("idle u%0d busy", inst),  busy_v[inst],  0);
        chk($sformatf("idle u%0d empty", inst), empty_v[inst], 1);
        chk($sformatf("idle u%0d count", inst), cnt_v[inst],   0);
    endtask

    // Writes wq[0..n-1] on consecutive edges; expects the first nacc to be sent.
    task automatic send_burst(input int inst, input int n, input int nacc, input int exp_ovf);
        @(posedge clk); #1;
        pk = 0; bcnt = 0; ocnt = 0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    wdat_v[inst] = 9'(wq[i]);
                    wen_v[inst]  = 1'b1;
                    @(posedge clk); #1;
                end
                wen_v[inst] = 1'b0;
            end
            begin
                @(posedge clk);          // write edge k
                @(posedge clk);          // pop edge k+1, start bit follows
                for (int i = 0; i < nacc; i++) expect_frame(inst, wq[i]);
            end
        join
        chk($sformatf("u%0d busy cycles", inst), bcnt, nacc * fl(inst));
        chk($sformatf("u%0d overflow pulses", inst), ocnt, exp_ovf);
        idle_check(inst);
    endtask

    task automatic rand_words(input int inst, input int n);
        for (int i = 0; i < n; i++) wq[i] = int'($urandom_range(0, (1 << DB[inst]) - 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic lo, bo;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin wen_v[i] = 1'b0; wdat_v[i] = '0; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset u%0d line", i),     line_v[i],  1);
            chk($sformatf("reset u%0d busy", i),     busy_v[i],  0);
            chk($sformatf("reset u%0d empty", i),    empty_v[i], 1);
            chk($sformatf("reset u%0d full", i),     full_v[i],  0);
            chk($sformatf("reset u%0d count", i),    cnt_v[i],   0);
            chk($sformatf("reset u%0d overflow", i), ovf_v[i],   0);
        end

        // 8N1, 0x55: check write-to-start latency explicitly
        @(posedge clk); #1;
        pk = 0; bcnt = 0; ocnt = 0;
        wdat_v[0] = 9'h055; wen_v[0] = 1'b1;
        @(posedge clk); #1;                    // edge k
        wen_v[0] = 1'b0;
        @(negedge clk);
        chk("latency empty after k", empty_v[0], 0);
        chk("latency count after k", cnt_v[0], 1);
        chk("latency line after k", line_v[0], 1);
        chk("latency busy after k", busy_v[0], 0);
        expect_frame(0, 'h55);
        chk("8N1 busy cycles", bcnt, 100);
        idle_check(0);

        // parity / stop-bit formats, 0x07
        wq[0] = 'h07; send_burst(1, 1, 1, 0);  // 8E1: parity 1, 110 cycles
        wq[0] = 'h07; send_burst(2, 1, 1, 0);  // 8O2: parity 0, 120 cycles
        chk("8O2 frame length", fl(2), 120);

        // 5N1 back-to-back
        wq[0] = 'h1F; wq[1] = 'h00; send_burst(3, 2, 2, 0);

        // 17 writes fit (first pops immediately), 18 overflow once
        rand_words(0, 17); send_burst(0, 17, 17, 0);
        chk("17 writes peak count", pk, 16);
        rand_words(0, 18); send_burst(0, 18, 17, 1);
        chk("18 writes peak count", pk, 16);

        // randomized bursts on the parity and 5-bit formats
        for (int r = 0; r < 3; r++) begin
            int n;
            n = int'($urandom_range(1, 6)); rand_words(1, n); send_burst(1, n, n, 0);
            n = int'($urandom_range(1, 6)); rand_words(3, n); send_burst(3, n, n, 0);
        end

        // pointer wrap: 40 words in bursts of 10
        for (int r = 0; r < 4; r++) begin
            rand_words(0, 10); send_burst(0, 10, 10, 0);
        end

        // reset mid-DATA with 3 words queued
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            wdat_v[0] = 9'($urandom_range(0, 255)); wen_v[0] = 1'b1;
            @(posedge clk); #1;
        end
        wen_v[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("pre-reset count", cnt_v[0], 3);
        chk("pre-reset busy", busy_v[0], 1);
        reset = 1'b1;
        #2;                                    // no clock edge in between
        chk("async reset line", line_v[0], 1);
        chk("async reset busy", busy_v[0], 0);
        chk("async reset count", cnt_v[0], 0);
        chk("async reset empty", empty_v[0], 1);
        #4 reset = 1'b0;
        lo = 1'b1; bo = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (line_v[0] !== 1'b1) lo = line_v[0];
            if (busy_v[0] !== 1'b0) bo = busy_v[0];
        end
        chk("post-reset line idle", lo, 1);
        chk("post-reset busy idle", bo, 0);
        idle_check(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, replacing the fixed 8N1 transmitter that drives `uart_tx_path` on the demo board. Upstream logic pushes words through a write strobe; the block serialises them back-to-back with configurable baud rate, data width, parity and stop bits. It sits between on-board data producers and the `uart_tx_path` pin, clocked from the 50 MHz board clock.

## Interface
- `CLK_FREQ`, 50_000_000, input clock frequency in Hz
- `BAUD`, 115200, line rate; bit period `BAUD_DIV = CLK_FREQ / BAUD` cycles (integer division, must be ≥ 2)
- `DATA_BITS`, 8, data bits per frame, 5..9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, 1 or 2
- `FIFO_DEPTH`, 16, FIFO entries, power of two, ≥ 2
- `clk_50m`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write strobe, one word per cycle while high
- `wr_data`  in  DATA_BITS  word to transmit
- `full`  out  1  FIFO holds FIFO_DEPTH words
- `empty`  out  1  FIFO holds 0 words
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words currently stored
- `overflow`  out  1  one-cycle pulse when a write is dropped
- `busy`  out  1  high while a frame is on the line (start bit through last stop bit)
- `uart_tx_path`  out  1  serial output, idle high

## Operation
- Reset values: `uart_tx_path`=1, `busy`=0, `full`=0, `empty`=1, `fifo_count`=0, `overflow`=0; FIFO pointers and FSM cleared. Reset mid-frame aborts the frame: line returns high immediately (async), and queued words are discarded.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH. A write is accepted when `wr_en`=1 and `full`=0 at the clock edge. When `wr_en`=1 and `full`=1, the write is dropped and `overflow` pulses for that one cycle, even if a pop occurs on the same edge (`full` is the registered value).
- Simultaneous accepted write and pop: `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `empty`=0: pop the head word into the shift register, drive 0.
  - START → DATA after BAUD_DIV cycles.
  - DATA: LSB first, one bit per BAUD_DIV cycles, bit counter 0..DATA_BITS-1. Then → PARITY if `PARITY`≠0, else → STOP.
  - PARITY: odd parity drives ~^data; even parity drives ^data; one bit period.
  - STOP: drive 1 for STOP_BITS × BAUD_DIV cycles. Then → START directly (popping) if FIFO non-empty, else → IDLE.
- Baud counter reloads to 0 at every state entry; bit boundaries are exact, with no fractional accumulation.
- `uart_tx_path` is a registered output, glitch-free.

## Timing
- Latency: write accepted at edge k into an empty FIFO with FSM in IDLE → `empty` low after edge k, pop at edge k+1, `uart_tx_path`=0 and `busy`=1 after edge k+1.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles exactly.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle, with no idle gap. `busy` stays high across the boundary.
- `busy` falls on the edge that enters IDLE.
- `full`/`empty`/`fifo_count` update on the same edge as the write or pop that changes them.

## Test plan
- Reset, 8N1, BAUD=5_000_000 (BAUD_DIV=10), write 0x55 → line 0 for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then 1 for 10 cycles; total 100 cycles; `busy` high exactly 100 cycles, start bit at edge k+1.
- PARITY=2 and PARITY=1, write 0x07 → parity bit 1 (even) / 0 (odd); frame length 110 cycles; STOP_BITS=2 → 120 cycles.
- Write 17 words in consecutive cycles with depth 16 and FSM idle → first pops at k+1, so all 17 are accepted and no overflow. Write 18 words → exactly one `overflow` pulse; `fifo_count` peaks at 16; transmitted sequence equals accepted words, with no gap between frames.
- DATA_BITS=5, write 0x1F and 0x00 back-to-back → frames of 70 cycles each; second start bit immediately follows first stop bit.
- Assert `reset` mid-DATA with 3 words queued → `uart_tx_path`=1 without waiting for a clock, `fifo_count`=0, `busy`=0; after release, the line stays idle.
- Pointer wrap: push/pop 40 words in bursts of 10 → all 40 are received in order, `empty`=1 at the end.
